pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program counter for the fetch stage. Selects the next PC each cycle:
//  reset, trap, redirect (branch/jump/call), return-stack pop, stall hold or sequential increment.
//  Adds a trap vector with exception PC (epc), misaligned-target detection and an optional return address stack (RAS).
//  Drives the instruction-memory address; redirect, call and ret come from execute, trap from the exception logic.
// PARAMETERS
//  PC_W       16        PC width in bits
//  STEP       4         sequential increment; power of two, >=1
//  RESET_VEC  0         PC loaded on reset
//  TRAP_VEC   'h0010    PC loaded on trap or misaligned redirect
//  RAS_DEPTH  4         return-stack entries; power of two, >=2 (used only with PC_RAS_EN)
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     synchronous, active-high
//  stall          in   1     hold PC (fetch back-pressure)
//  trap           in   1     take exception this cycle
//  redirect_valid in   1     load redirect_target
//  redirect_target in  PC_W  branch/jump/call target
//  call           in   1     qualifies redirect_valid: push pc+STEP onto the RAS
//  ret            in   1     pop RAS top into pc (ignored when redirect_valid=1)
//  pc             out  PC_W  current fetch address
//  epc            out  PC_W  pc value captured at the last trap
//  misalign       out  1     1-cycle pulse: a misaligned redirect was converted to a trap
//  ras_empty      out  1     RAS holds 0 entries
//  ras_full       out  1     RAS holds RAS_DEPTH entries
//  ras_underflow  out  1     1-cycle pulse: ret was issued on an empty RAS
// BEHAVIOUR
//  - All state updates on posedge clk. Outputs are registered. Next-PC latency is one cycle.
//  - Reset values: pc=RESET_VEC, epc=0, misalign=0, ras_underflow=0, ras count=0, ras_empty=1, ras_full=0.
//    Reset takes effect mid-operation and discards a pending redirect, trap or stack contents.
//  - Priority, highest first:
//    reset > trap > redirect_valid > ret > stall > sequential.
//  - trap: pc<=TRAP_VEC, epc<=pc. A trap ignores stall and cancels a same-cycle redirect, call or ret; the RAS is unchanged.
//  - redirect_valid: if redirect_target[log2(STEP)-1:0]!=0, treat as trap:
//    pc<=TRAP_VEC, epc<=pc, misalign=1 for one cycle, and no push.
//    Otherwise pc<=redirect_target. This overrides stall.
//  - redirect_valid with call (aligned): push (pc+STEP) mod 2^PC_W.
//    When the RAS is full, the push overwrites the oldest entry (circular) and the count stays at RAS_DEPTH.
//  - ret without redirect_valid: if non-empty, pc<=top and pop. This overrides stall.
//    If empty, pc<=pc+STEP, ras_underflow=1 for one cycle, and the count stays 0.
//  - call without redirect_valid: ignored.
//  - stall: pc holds.
//  - Otherwise pc<=(pc+STEP) mod 2^PC_W; the carry out is discarded (wrap-around is legal).
//  - ras_empty/ras_full reflect the post-update count in the same edge.
// CONFIGURATION
//  PC_RAS_EN defined:
//    RAS built as described.
//  PC_RAS_EN undefined:
//    No stack storage. call and ret are ignored (ret behaves as sequential/stall).
//    ras_empty=1, ras_full=0, ras_underflow=0 constant. RAS_DEPTH unused.
// TESTING (defaults; PC_RAS_EN defined unless noted)
//  1. reset 1 cycle, then 4 idle cycles -> pc 0,4,8,12,16; stall 2 cycles at 16 -> pc stays 16,16 then 20.
//  2. At pc=0x0020: redirect_valid, target=0x0100, with stall=1 -> pc=0x0100 next cycle.
//     target=0x0102 -> pc=0x0010, epc=0x0020, misalign pulse.
//  3. trap and redirect in the same cycle at pc=0x0040 -> pc=0x0010, epc=0x0040.
//  4. 5 calls from 0x0000,0x0100,0x0200,0x0300,0x0400 (each to next) -> ras_full after 4th; 5 rets -> pcs
//     0x0404,0x0304,0x0204,0x0104 then ras_empty; 5th ret at 0x0104 -> pc=0x0108, ras_underflow pulse.
//  5. PC_W=16, pc=0xFFFC, idle -> pc=0x0000.
//     Reset asserted during a ret -> pc=RESET_VEC, ras_empty=1.
//  6. PC_RAS_EN undefined: call to 0x0100 then ret -> pc 0x0100, 0x0104; ras_empty stays 1, no underflow pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC selection: reset, trap, redirect, return-stack pop, stall hold or increment.
// Optional return address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int unsigned          PC_W      = 16,
    parameter int unsigned          STEP      = 4,
    parameter logic [PC_W-1:0]      RESET_VEC = '0,
    parameter logic [PC_W-1:0]      TRAP_VEC  = 'h0010,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] epc,
    output logic            misalign,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;
    logic            uf_q, uf_d;
    logic            push, pop;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + STEP_V;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next write slot; a push onto a full stack overwrites the oldest entry.
    assign top_idx = ptr_q - PTR_W'(1);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) ras_q[ptr_q] <= pc_inc;
    end

    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_underflow = uf_q;
`else
    logic unused_ok;
    assign unused_ok     = ^{call, ret, push, pop, uf_q, 32'(RAS_DEPTH)};
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        mis_d = 1'b0;
        uf_d  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (trap) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
        end else if (redirect_valid) begin
            if ((redirect_target & ALIGN_MASK) != '0) begin
                pc_d  = TRAP_VEC;
                epc_d = pc_q;
                mis_d = 1'b1;
            end else begin
                pc_d = redirect_target;
                push = call;
            end
        end
`ifdef PC_RAS_EN
        else if (ret) begin
            if (cnt_q != '0) begin
                pc_d = ras_q[top_idx];
                pop  = 1'b1;
            end else begin
                pc_d = pc_inc;
                uf_d = 1'b1;
            end
        end
`endif
        else if (!stall) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            mis_q <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
            uf_q  <= uf_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign misalign = mis_q;

endmodule
